// File: rtl/regex_stream_controller_pkg.sv
// regex_stream_controller_pkg: shared defaults and lane-mode encodings for the regex stream bridge
package regex_stream_controller_pkg;
   localparam int DATA_WIDTH_DEFAULT = 8;
   localparam logic [7:0] BUBBLE_BYTE_DEFAULT = 8'h00;
   typedef enum logic {MODE_REPLICATE = 1'b0, MODE_PACK = 1'b1} mode_e;
endpackage

// File: rtl/regex_stream_controller_stream_fifo.sv
// regex_stream_controller_stream_fifo: synchronous result FIFO with occupancy count
// A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
module regex_stream_controller_stream_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clock_i,
   input  logic                       reset_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           data_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
   output logic                       empty_o
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0] rd_q, wr_q;
   logic [AW:0] count_q;
   logic do_push, do_pop;
   assign full_o = count_q == (AW+1)'(DEPTH);
   assign empty_o = count_q == '0;
   assign count_o = count_q;
   assign data_o = mem_q[rd_q];
   assign do_pop = pop_i & !empty_o;
   assign do_push = push_i & (!full_o | do_pop);
   always_ff @(posedge clock_i) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end
   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         rd_q <= '0;
         wr_q <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop) rd_q <= rd_q + 1'b1;
         count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/regex_stream_controller.sv
// regex_stream_controller: credit-gated bridge from UART bytes to a fixed-latency regex processor
// Words are issued only when the result FIFO is guaranteed room; idle pipelines drain with bubbles.
module regex_stream_controller
   import regex_stream_controller_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
   parameter int REPLICATION_FACTOR = 3,
   parameter int PIPELINE_LATENCY = 2,
   parameter int FIFO_DEPTH = 16,
   parameter int IDLE_TIMEOUT = 1024,
   parameter logic [DATA_WIDTH-1:0] BUBBLE_BYTE = BUBBLE_BYTE_DEFAULT
) (
   input  logic                                     clock_i,
   input  logic                                     reset_i,
   input  logic                                     mode_i,
   input  logic [DATA_WIDTH-1:0]                    in_data_i,
   input  logic                                     in_valid_i,
   output logic                                     in_ready_o,
   output logic                                     proc_enable_o,
   output logic [REPLICATION_FACTOR*DATA_WIDTH-1:0] proc_data_in_o,
   input  logic [DATA_WIDTH-1:0]                    proc_data_out_i,
   output logic [DATA_WIDTH-1:0]                    out_data_o,
   output logic                                     out_valid_o,
   input  logic                                     out_ready_i,
   output logic                                     busy_o,
   output logic                                     overflow_error_o
);
   localparam int R = REPLICATION_FACTOR;
   localparam int L = PIPELINE_LATENCY;
   localparam int WW = R * DATA_WIDTH;
   localparam int XW = (R > 1) ? $clog2(R) : 1;
   localparam int IW = $clog2(IDLE_TIMEOUT + 1);
   localparam int FW = $clog2(FIFO_DEPTH) + 1;
   localparam int CW = $clog2(FIFO_DEPTH + L + 2) + 1;
   logic [XW-1:0] idx_q, idx_d;
   logic word_full_q, word_full_d;
   logic [WW-1:0] word_q, word_d;
   mode_e mode_q, mode_d, cur_mode;
   logic [L-1:0] tag_q, tag_d, tag_sh;
   logic push_pending_q, push_pending_d;
   logic [IW-1:0] idle_q, idle_d;
   logic overflow_q, overflow_d;
   logic [CW-1:0] in_flight;
   logic credit_ok, issue_real, issue_bubble, enable, in_ready, accept, draining, pop;
   logic [FW-1:0] fifo_count;
   logic fifo_full, fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_head;
   regex_stream_controller_stream_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clock_i(clock_i),
      .reset_i(reset_i),
      .push_i(push_pending_q),
      .data_i(proc_data_out_i),
      .pop_i(pop),
      .data_o(fifo_head),
      .count_o(fifo_count),
      .full_o(fifo_full),
      .empty_o(fifo_empty)
   );
   // The top tag bit marks the stage whose result is already on proc_data_out, so it is not in flight.
   always_comb begin
      in_flight = '0;
      for (int i = 0; i < L; i++) in_flight = in_flight + CW'(tag_q[i]);
      in_flight = in_flight - CW'(tag_q[L-1]);
      credit_ok = CW'(fifo_count) + in_flight + CW'(push_pending_q) < CW'(FIFO_DEPTH);
      issue_real = word_full_q & credit_ok;
      draining = idle_q == IW'(IDLE_TIMEOUT);
      issue_bubble = draining & !word_full_q & (in_flight != '0) & credit_ok;
      enable = issue_real | issue_bubble;
      in_ready = !word_full_q | issue_real;
      accept = in_valid_i & in_ready;
      pop = !fifo_empty & out_ready_i;
      cur_mode = (idx_q == '0) ? mode_e'(mode_i) : mode_q;
      word_d = word_q;
      idx_d = idx_q;
      mode_d = mode_q;
      word_full_d = word_full_q & !issue_real;
      if (accept) begin
         mode_d = cur_mode;
         if (cur_mode == MODE_REPLICATE) begin
            word_d = {R{in_data_i}};
            word_full_d = 1'b1;
         end else begin
            word_d[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] = in_data_i;
            idx_d = (idx_q == XW'(R-1)) ? '0 : idx_q + 1'b1;
            word_full_d = idx_q == XW'(R-1);
         end
      end
      tag_sh = L'({tag_q, issue_real});
      tag_d = enable ? tag_sh : tag_q;
      push_pending_d = enable & tag_sh[L-1];
      idle_d = (accept || in_flight == '0) ? '0 : (draining ? idle_q : idle_q + 1'b1);
      overflow_d = overflow_q | (push_pending_q & fifo_full & !pop);
   end
   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         idx_q <= '0;
         word_full_q <= 1'b0;
         word_q <= '0;
         mode_q <= MODE_REPLICATE;
         tag_q <= '0;
         push_pending_q <= 1'b0;
         idle_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         idx_q <= idx_d;
         word_full_q <= word_full_d;
         word_q <= word_d;
         mode_q <= mode_d;
         tag_q <= tag_d;
         push_pending_q <= push_pending_d;
         idle_q <= idle_d;
         overflow_q <= overflow_d;
      end
   end
   assign in_ready_o = reset_i & in_ready;
   assign proc_enable_o = reset_i & enable;
   assign proc_data_in_o = !reset_i ? '0 : (issue_bubble ? {R{BUBBLE_BYTE}} : word_q);
   assign out_valid_o = reset_i & !fifo_empty;
   assign out_data_o = out_valid_o ? fifo_head : '0;
   assign busy_o = reset_i & ((idx_q != '0) | word_full_q | (in_flight != '0) | push_pending_q | !fifo_empty);
   assign overflow_error_o = reset_i & overflow_q;
endmodule

// File: tb/tb_regex_stream_controller.sv
// tb_regex_stream_controller: randomized and directed checks against a queue-based model
// A bench-side enable-gated pipeline stands in for the regex processor.
module tb_regex_stream_controller;
   localparam int L = 4;
   localparam int DEPTH = 4;
   logic clk = 1'b0, rst_n = 1'b0, mode = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic [7:0] in_data = '0;
   logic in_ready, proc_enable, out_valid, busy, overflow;
   logic [23:0] proc_data_in;
   logic [7:0] proc_data_out, out_data;
   logic [7:0] pipe [L];
   int tests = 0, fails = 0;
   logic [23:0] exp_words[$], wlog[$], part, w_m;
   logic [7:0] exp_res[$], olog[$];
   int pos = 0, cyc = 0, real_cnt = 0, bub_cnt = 0, pop_cnt = 0, last_real = 0, gap = 0;
   bit part_mode = 0, bub_seen = 0, real_en = 0, rnd_done = 0;
   int s_real, s_bub, s_pop;

   regex_stream_controller #(
      .DATA_WIDTH(8), .REPLICATION_FACTOR(3), .PIPELINE_LATENCY(L),
      .FIFO_DEPTH(DEPTH), .IDLE_TIMEOUT(16), .BUBBLE_BYTE(8'h00)
   ) dut (
      .clock_i(clk), .reset_i(rst_n), .mode_i(mode), .in_data_i(in_data),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .proc_enable_o(proc_enable),
      .proc_data_in_o(proc_data_in), .proc_data_out_i(proc_data_out),
      .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .busy_o(busy), .overflow_error_o(overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] proc_f(input logic [23:0] w);
      return w[7:0] ^ (w[15:8] + 8'd1) ^ {w[20:16], w[23:21]};
   endfunction

   always @(posedge clk) if (proc_enable) begin
      pipe[0] <= proc_f(proc_data_in);
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
   end
   assign proc_data_out = pipe[L-1];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic flag(input string msg);
      tests++;
      fails++;
      $display("FAIL %s", msg);
   endtask

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         check("reset_outputs", {in_ready, proc_enable, out_valid, busy, overflow, |proc_data_in, |out_data}, 0);
         exp_words.delete();
         exp_res.delete();
         pos = 0;
      end else begin
         check("overflow", overflow, 0);
         check("busy", busy, exp_res.size() != 0 || exp_words.size() != 0 || pos != 0);
         real_en = proc_enable && proc_data_in != 24'h0;
         check("in_ready", in_ready, exp_words.size() == 0 || real_en);
         if (proc_enable && !real_en) begin
            bub_cnt++;
            if (!bub_seen) gap = cyc - last_real;
            bub_seen = 1;
            check("bubble_with_word_ready", exp_words.size(), 0);
         end else if (real_en) begin
            if (exp_words.size() == 0) flag($sformatf("issue_unformed: word %h issued with no complete word", proc_data_in));
            else begin
               w_m = exp_words.pop_front();
               check("issue_word", proc_data_in, w_m);
               wlog.push_back(w_m);
               exp_res.push_back(proc_f(w_m));
               real_cnt++;
               last_real = cyc;
               bub_seen = 0;
               check("credit_bound", exp_res.size() <= DEPTH, 1);
            end
         end
         if (in_valid && in_ready) begin
            if (pos == 0) part_mode = mode;
            if (!part_mode) exp_words.push_back({3{in_data}});
            else begin
               part[pos*8 +: 8] = in_data;
               pos++;
               if (pos == 3) begin
                  exp_words.push_back(part);
                  pos = 0;
               end
            end
         end
         if (out_valid && out_ready) begin
            if (exp_res.size() == 0) flag($sformatf("out_unexpected: got %h, expected none", out_data));
            else check("out_data", out_data, exp_res.pop_front());
            olog.push_back(out_data);
            pop_cnt++;
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b);
      bit ok = 0;
      in_data = b;
      in_valid = 1'b1;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!ok) flag($sformatf("send_timeout: byte %h not accepted, expected accept", b));
   endtask

   task automatic wait_idle();
      bit done = 0;
      for (int i = 0; i < 600 && !done; i++) begin
         @(negedge clk);
         done = !busy;
      end
      if (!done) flag("idle_timeout: busy stuck at 1, expected 0");
      @(posedge clk);
      #1;
   endtask

   task automatic mark();
      wlog.delete();
      olog.delete();
      s_real = real_cnt;
      s_bub = bub_cnt;
      s_pop = pop_cnt;
   endtask

   initial begin
      cycles(3);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_in_ready", in_ready, 1);
      check("post_reset_busy", busy, 0);
      cycles(1);
      // replicate mode
      mark();
      send(8'h41);
      send(8'h42);
      wait_idle();
      check("t1_word_count", wlog.size(), 2);
      check("t1_out_count", olog.size(), 2);
      if (wlog.size() == 2 && olog.size() == 2) begin
         check("t1_word0", wlog[0], 24'h414141);
         check("t1_word1", wlog[1], 24'h424242);
         check("t1_out0", olog[0], proc_f(24'h414141));
         check("t1_out1", olog[1], proc_f(24'h424242));
      end
      // pack mode: partial word held
      mark();
      mode = 1'b1;
      send(8'h01);
      send(8'h02);
      repeat (10) @(negedge clk);
      check("t2_partial_no_issue", real_cnt - s_real, 0);
      check("t2_partial_busy", busy, 1);
      cycles(1);
      send(8'h03);
      wait_idle();
      check("t2_word_count", wlog.size(), 1);
      if (wlog.size() == 1) check("t2_word", wlog[0], 24'h030201);
      // backpressure
      mark();
      mode = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(8'h10 + 8'(i));
      repeat (10) @(negedge clk);
      check("t3_enables", real_cnt - s_real, DEPTH);
      check("t3_in_ready_low", in_ready, 0);
      cycles(1);
      out_ready = 1'b1;
      for (int i = 5; i < 8; i++) send(8'h10 + 8'(i));
      wait_idle();
      check("t3_out_count", olog.size(), 8);
      if (olog.size() == 8)
         for (int i = 0; i < 8; i++) check("t3_out_order", olog[i], proc_f({3{8'h10 + 8'(i)}}));
      // drain
      mark();
      send(8'h77);
      wait_idle();
      check("t4_real", real_cnt - s_real, 1);
      check("t4_bubbles", bub_cnt - s_bub, L - 1);
      check("t4_idle_gap", gap, 17);
      check("t4_out_count", olog.size(), 1);
      check("t4_busy", busy, 0);
      // mode change mid-word
      mark();
      mode = 1'b1;
      send(8'h11);
      mode = 1'b0;
      send(8'h22);
      send(8'h33);
      send(8'h44);
      wait_idle();
      check("t5_word_count", wlog.size(), 2);
      if (wlog.size() == 2) begin
         check("t5_packed", wlog[0], 24'h332211);
         check("t5_replicated", wlog[1], 24'h444444);
      end
      // reset with work outstanding
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(8'h60 + 8'(i));
      cycles(2);
      rst_n = 1'b0;
      cycles(2);
      rst_n = 1'b1;
      out_ready = 1'b1;
      mark();
      repeat (40) @(negedge clk);
      check("t6_no_stale_out", pop_cnt - s_pop, 0);
      cycles(1);
      send(8'h5a);
      send(8'ha5);
      wait_idle();
      check("t6_out_count", olog.size(), 2);
      if (olog.size() == 2) begin
         check("t6_out0", olog[0], proc_f(24'h5a5a5a));
         check("t6_out1", olog[1], proc_f(24'ha5a5a5));
      end
      // randomized traffic with random backpressure
      mark();
      fork
         begin
            for (int n = 0; n < 300; n++) begin
               if ($urandom_range(0, 7) == 0) mode = ~mode;
               send(8'($urandom_range(1, 255)));
               cycles(($urandom_range(0, 31) == 0) ? 25 : $urandom_range(0, 2));
            end
            rnd_done = 1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1;
               out_ready = $urandom_range(0, 3) != 0;
            end
         end
      join
      out_ready = 1'b1;
      if (pos != 0) begin
         mode = 1'b1;
         while (pos != 0 && real_cnt - s_real < 400) send(8'h99);
      end
      wait_idle();
      check("rand_all_out", pop_cnt - s_pop, real_cnt - s_real);
      check("rand_res_empty", exp_res.size(), 0);
      check("rand_words_empty", exp_words.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
